// File: rtl/cu_pkg.sv
// cu_pkg: shared state encoding, select codes and condition evaluation for the multicycle controller
package cu_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } state_e;
  localparam logic [3:0] COND_EQ = 4'd0, COND_NE = 4'd1, COND_CS = 4'd2, COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4, COND_PL = 4'd5, COND_VS = 4'd6, COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8, COND_LS = 4'd9, COND_GE = 4'd10, COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14;
  localparam logic [1:0] SRCB_REG = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10;
  localparam logic [1:0] OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10;
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: cond_holds = z;
      COND_NE: cond_holds = !z;
      COND_CS: cond_holds = c;
      COND_CC: cond_holds = !c;
      COND_MI: cond_holds = n;
      COND_PL: cond_holds = !n;
      COND_VS: cond_holds = v;
      COND_VC: cond_holds = !v;
      COND_HI: cond_holds = c & !z;
      COND_LS: cond_holds = !c | z;
      COND_GE: cond_holds = n == v;
      COND_LT: cond_holds = n != v;
      COND_GT: cond_holds = !z & (n == v);
      COND_LE: cond_holds = z | (n != v);
      COND_AL: cond_holds = 1'b1;
      default: cond_holds = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/cu_cond_logic.sv
// cu_cond_logic: NZCV flags, latched condition result and gating of architectural writes
module cu_cond_logic
  import cu_pkg::*;
#(
  parameter logic [3:0] PC_REG = 4'd15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic [1:0] flag_w_i,
  input  logic [3:0] rd_i,
  input  logic       decode_i,
  input  logic       exec_i,
  input  logic       next_pc_i,
  input  logic       reg_w_i,
  input  logic       mem_w_i,
  input  logic       branch_i,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic       mem_write_o
);
  logic [3:0] nzcv_q, nzcv_d;
  logic       cond_ex_q, cond_ex_d;
  logic       pcs;
  always_comb begin
    cond_ex_d = decode_i ? cond_holds(cond_i, nzcv_q) : cond_ex_q;
    nzcv_d = nzcv_q;
    nzcv_d[3:2] = (exec_i && cond_ex_q && flag_w_i[1]) ? alu_flags_i[3:2] : nzcv_q[3:2];
    nzcv_d[1:0] = (exec_i && cond_ex_q && flag_w_i[0]) ? alu_flags_i[1:0] : nzcv_q[1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      nzcv_q    <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      nzcv_q    <= nzcv_d;
      cond_ex_q <= cond_ex_d;
    end
  end
  // Reset suppresses every write so an aborted instruction leaves no trace
  always_comb begin
    pcs         = reg_w_i & (rd_i == PC_REG);
    reg_write_o = !reset & reg_w_i & cond_ex_q;
    mem_write_o = !reset & mem_w_i & cond_ex_q;
    pc_write_o  = !reset & (next_pc_i | ((branch_i | pcs) & cond_ex_q));
  end
endmodule

// File: rtl/cu_multicycle_ctrl.sv
// cu_multicycle_ctrl: Moore FSM sequencing fetch/decode/execute/memory/writeback with datapath select decode
module cu_multicycle_ctrl
  import cu_pkg::*;
#(
  parameter int         STATE_W = 4,
  parameter logic [3:0] PC_REG  = 4'd15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  output logic       ALUOp,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite
);
  logic [STATE_W-1:0] state_q, state_d, s;
  logic               fetch_like, next_pc, reg_w, mem_w, branch;
  logic               unused_funct;
  assign unused_funct = ^Funct[4:1];
  always_comb begin
    state_d = STATE_W'(S_FETCH);
    case (state_q)
      S_FETCH:  state_d = STATE_W'(S_DECODE);
      S_DECODE: state_d = Op == OP_MEM ? STATE_W'(S_MEMADR)
                        : Op == OP_DP  ? (Funct[5] ? STATE_W'(S_EXECI) : STATE_W'(S_EXECR))
                        : Op == OP_BR  ? STATE_W'(S_BRANCH) : STATE_W'(S_FETCH);
      S_MEMADR: state_d = Funct[0] ? STATE_W'(S_MEMRD) : STATE_W'(S_MEMWR);
      S_MEMRD:  state_d = STATE_W'(S_MEMWB);
      S_EXECR:  state_d = STATE_W'(S_ALUWB);
      S_EXECI:  state_d = STATE_W'(S_ALUWB);
      default:  state_d = STATE_W'(S_FETCH);
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) state_q <= STATE_W'(S_FETCH);
    else       state_q <= state_d;
  end
  // During reset the selects already present the FETCH pattern
  always_comb begin
    s          = reset ? STATE_W'(S_FETCH) : state_q;
    fetch_like = (s == STATE_W'(S_FETCH)) || (s == STATE_W'(S_DECODE));
    ALUOp      = (s == STATE_W'(S_EXECR)) || (s == STATE_W'(S_EXECI));
    IRWrite    = !reset && (s == STATE_W'(S_FETCH));
    AdrSrc     = (s == STATE_W'(S_MEMRD)) || (s == STATE_W'(S_MEMWR));
    ALUSrcA    = fetch_like;
    ALUSrcB    = fetch_like ? SRCB_FOUR
               : ((s == STATE_W'(S_MEMADR)) || (s == STATE_W'(S_EXECI)) || (s == STATE_W'(S_BRANCH))) ? SRCB_IMM
               : SRCB_REG;
    ResultSrc  = (fetch_like || (s == STATE_W'(S_BRANCH))) ? RES_ALURESULT
               : (s == STATE_W'(S_MEMWB)) ? RES_DATA : RES_ALUOUT;
    next_pc    = s == STATE_W'(S_FETCH);
    reg_w      = (s == STATE_W'(S_MEMWB)) || (s == STATE_W'(S_ALUWB));
    mem_w      = s == STATE_W'(S_MEMWR);
    branch     = s == STATE_W'(S_BRANCH);
  end
  cu_cond_logic #(.PC_REG(PC_REG)) u_cond (
    .clk         (clk),
    .reset       (reset),
    .cond_i      (Cond),
    .alu_flags_i (ALUFlags),
    .flag_w_i    (FlagW),
    .rd_i        (Rd),
    .decode_i    (state_q == STATE_W'(S_DECODE)),
    .exec_i      ((state_q == STATE_W'(S_EXECR)) || (state_q == STATE_W'(S_EXECI))),
    .next_pc_i   (next_pc),
    .reg_w_i     (reg_w),
    .mem_w_i     (mem_w),
    .branch_i    (branch),
    .pc_write_o  (PCWrite),
    .reg_write_o (RegWrite),
    .mem_write_o (MemWrite)
  );
endmodule

// File: tb/tb_cu_multicycle_ctrl.sv
// tb_cu_multicycle_ctrl: per-instruction phase model of the controller checked cycle by cycle
module tb_cu_multicycle_ctrl;
  logic       clk = 1'b0, reset = 1'b1;
  logic [1:0] Op = '0, FlagW = '0;
  logic [5:0] Funct = '0;
  logic [3:0] Rd = '0, Cond = '0, ALUFlags = '0;
  logic       ALUOp, IRWrite, AdrSrc, ALUSrcA, PCWrite, RegWrite, MemWrite;
  logic [1:0] ALUSrcB, ResultSrc;
  logic [10:0] act;
  logic [3:0]  m_nzcv = 4'b0000;
  int          errors = 0, checks = 0;
  localparam logic [10:0] RESET_VEC = 11'b0_0_0_1_10_10_0_0_0;

  cu_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .ALUOp(ALUOp), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite)
  );

  always #5 clk = ~clk;
  assign act = {ALUOp, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, PCWrite, RegWrite, MemWrite};

  function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    logic [15:0] t;
    {n, z, c, v} = f;
    t = {1'b0, 1'b1, z | (n != v), !z & (n == v), n != v, n == v, !c | z, c & !z,
         !v, v, !n, n, !c, c, !z, z};
    return t[cc];
  endfunction

  function automatic int latency(input logic [1:0] op, input logic [5:0] funct);
    return op == 2'b11 ? 2 : op == 2'b10 ? 3 : (op == 2'b01 && funct[0]) ? 5 : 4;
  endfunction

  // Expected output vector for cycle k of one instruction
  function automatic logic [10:0] exp_vec(input logic [1:0] op, input logic [5:0] funct,
                                          input logic [3:0] rd, input logic ok, input int k);
    logic aop = 0, ir = 0, adr = 0, a = 0, pcw = 0, rw = 0, mw = 0;
    logic [1:0] b = 0, res = 0;
    if (k < 2) begin
      a = 1; b = 2; res = 2; ir = k == 0; pcw = k == 0;
    end else if (op == 2'b00) begin
      if (k == 2) begin aop = 1; b = funct[5] ? 2'd1 : 2'd0; end
      else begin rw = ok; pcw = ok && rd == 4'd15; end
    end else if (op == 2'b01) begin
      if (k == 2) b = 1;
      else if (!funct[0]) begin adr = 1; mw = ok; end
      else if (k == 3) adr = 1;
      else begin res = 1; rw = ok; pcw = ok && rd == 4'd15; end
    end else begin
      b = 1; res = 2; pcw = ok;
    end
    return {aop, ir, adr, a, b, res, pcw, rw, mw};
  endfunction

  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                           input logic [3:0] cond, input logic [3:0] af, input logic [1:0] fw,
                           input string tag);
    logic ok;
    logic [10:0] e;
    Op = op; Funct = funct; Rd = rd; Cond = cond; ALUFlags = af; FlagW = fw;
    ok = cond_ok(cond, m_nzcv);
    for (int k = 0; k < latency(op, funct); k++) begin
      @(negedge clk);
      e = exp_vec(op, funct, rd, ok, k);
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s cycle%0d outputs got=%b want=%b", tag, k, act, e);
      end
      @(posedge clk); #1;
    end
    if (op == 2'b00 && ok) begin
      if (fw[1]) m_nzcv[3:2] = af[3:2];
      if (fw[0]) m_nzcv[1:0] = af[1:0];
    end
    checks++;
    if (dut.u_cond.nzcv_q !== m_nzcv) begin
      errors++;
      $display("FAIL %s flags got=%b want=%b", tag, dut.u_cond.nzcv_q, m_nzcv);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (act !== RESET_VEC) begin
        errors++;
        $display("FAIL reset outputs got=%b want=%b", act, RESET_VEC);
      end
      @(posedge clk); #1;
    end
    reset = 0;
    m_nzcv = 0;
    checks++;
    if (dut.u_cond.nzcv_q !== 4'b0000) begin
      errors++;
      $display("FAIL reset flags got=%b want=0000", dut.u_cond.nzcv_q);
    end
  endtask

  task automatic test_add();
    run_instr(2'b00, 6'b001000, 4'd3, 4'hE, 4'($urandom), 2'b00, "add");
  endtask

  task automatic test_ldr_str();
    run_instr(2'b01, 6'b011001, 4'd5, 4'hE, 4'($urandom), 2'($urandom), "ldr");
    run_instr(2'b01, 6'b011000, 4'd5, 4'hE, 4'($urandom), 2'($urandom), "str");
  endtask

  task automatic test_branch();
    run_instr(2'b00, 6'b000101, 4'd2, 4'hE, 4'b0100, 2'b11, "subs");
    run_instr(2'b10, 6'b100000, 4'd0, 4'h0, 4'($urandom), 2'b11, "beq");
    run_instr(2'b10, 6'b100000, 4'd0, 4'h1, 4'($urandom), 2'b11, "bne");
  endtask

  task automatic test_failed_cond();
    run_instr(2'b00, 6'b001001, 4'd4, 4'h1, 4'b1011, 2'b11, "addsne");
  endtask

  task automatic test_pc_dest();
    run_instr(2'b00, 6'b111010, 4'd15, 4'hE, 4'($urandom), 2'b00, "mov_pc");
  endtask

  task automatic test_mid_reset();
    run_instr(2'b00, 6'b000101, 4'd1, 4'hE, 4'b1011, 2'b11, "subs_pre");
    Op = 2'b01; Funct = 6'b011000; Rd = 4'd6; Cond = 4'hE;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (act !== exp_vec(Op, Funct, Rd, 1'b1, k)) begin
        errors++;
        $display("FAIL midreset_pre cycle%0d got=%b want=%b", k, act, exp_vec(Op, Funct, Rd, 1'b1, k));
      end
      @(posedge clk); #1;
    end
    reset = 1;
    @(negedge clk);
    checks++;
    if (act !== RESET_VEC) begin
      errors++;
      $display("FAIL midreset memwr got=%b want=%b", act, RESET_VEC);
    end
    @(posedge clk); #1;
    reset = 0;
    m_nzcv = 0;
    checks++;
    if (dut.u_cond.nzcv_q !== 4'b0000) begin
      errors++;
      $display("FAIL midreset flags got=%b want=0000", dut.u_cond.nzcv_q);
    end
    run_instr(2'b10, 6'b100000, 4'd0, 4'h0, 4'd0, 2'b00, "beq_after_reset");
  endtask

  task automatic test_unsupported();
    run_instr(2'b11, 6'($urandom), 4'($urandom), 4'hE, 4'($urandom), 2'b11, "undef");
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      logic [3:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      run_instr(2'($urandom), 6'($urandom), rd, 4'($urandom), 4'($urandom), 2'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldr_str();
    test_branch();
    test_failed_cond();
    test_pc_dest();
    test_mid_reset();
    test_unsupported();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cu_multicycle_ctrl.md
Name: cu_multicycle_ctrl

Overview:
- Multicycle main controller for the ARM-subset processor.
- A Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles. An integrated condition unit holds the NZCV flags and gates architectural writes.
- Drives the datapath mux selects and write enables.
- Emits ALUOp to the existing ALU decoder and takes its FlagW result back.

Parameters:
- STATE_W, 4, width of the state register.
- PC_REG, 4'd15, register index treated as the PC for PCS detection.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Op  in  2  instruction bits [27:26].
- Funct  in  6  instruction bits [25:20]; [5]=I, [0]=S or L.
- Rd  in  4  destination register field.
- Cond  in  4  instruction bits [31:28].
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle.
- FlagW  in  2  from the ALU decoder; [1] updates N,Z and [0] updates C,V.
- ALUOp  out  1  to the ALU decoder; 1 means decode by Funct.
- IRWrite  out  1  instruction register enable.
- AdrSrc  out  1  memory address select; 0=PC, 1=ALUResult register.
- ALUSrcA  out  1  0=register A, 1=PC.
- ALUSrcB  out  2  00=register B, 01=extended immediate, 10=constant 4.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- PCWrite  out  1  PC register enable.
- RegWrite  out  1  register file write enable.
- MemWrite  out  1  data memory write enable.

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high.
- Reset:
  - On a clk edge with reset=1: state<=FETCH, flags NZCV<=0000, cond_ex_q<=0.
  - While reset=1, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0.
  - The remaining selects show FETCH values.
  - Reset asserted mid-instruction aborts it; no write occurs in that cycle.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- Transitions:
  - FETCH->DECODE.
  - DECODE: Op=01->MEMADR; Op=00 & Funct[5]=0->EXECR; Op=00 & Funct[5]=1->EXECI; Op=10->BRANCH; Op=11->FETCH (unsupported instruction, treated as NOP).
  - MEMADR: Funct[0]=1->MEMRD, else ->MEMWR.
  - MEMRD->MEMWB->FETCH.
  - MEMWR->FETCH.
  - EXECR and EXECI->ALUWB->FETCH.
  - BRANCH->FETCH.
- Internal strobes: NextPC, RegW, MemW and Branch; all are 0 unless listed below.
- Moore outputs per state:
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10, IRWrite=1, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1.
  - Any unlisted select is 0.
- Condition evaluation:
  - In DECODE, Cond is evaluated against the flag registers and latched into cond_ex_q at the DECODE->next edge.
  - cond_ex_q governs every later state of that instruction.
  - Codes: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 -> 0.
- Write gating:
  - RegWrite = RegW & cond_ex_q.
  - MemWrite = MemW & cond_ex_q.
  - PCS = RegW & (Rd==PC_REG).
  - PCWrite = NextPC | ((Branch | PCS) & cond_ex_q).
- Flag update:
  - At the clk edge leaving EXECR or EXECI only: if cond_ex_q, then FlagW[1] loads N,Z from ALUFlags[3:2] and FlagW[0] loads C,V from ALUFlags[1:0].
  - FlagW is ignored in all other states.
  - An instruction that updates flags sees its own condition using the old flags (cond_ex_q is already latched).
- Latency: data-processing 4 cycles; LDR 5; STR 4; B 3; unsupported 2.

Decomposition:
- Shared package cu_pkg:
  - state enum typedef.
  - Cond code constants (EQ..AL).
  - ALUSrcB and ResultSrc select localparams.
  - Op encodings (DP=00, MEM=01, BR=10).
- One sub-module, cu_cond_logic:
  - Holds the NZCV registers and cond_ex_q.
  - Evaluates Cond and computes the gated PCWrite, RegWrite and MemWrite.
  - The top level holds only the FSM and its Moore output decode.

Test Plan:
- ADD register form:
  - Stimulus: reset 2 cycles, then Op=00, Funct=001000, Cond=1110, Rd=3.
  - Required: states FETCH,DECODE,EXECR,ALUWB,FETCH.
  - Required: RegWrite=1 only in ALUWB; ALUOp=1 only in EXECR; flags unchanged.
- LDR then STR:
  - LDR (Op=01, Funct[0]=1): MEMRD has AdrSrc=1; MEMWB has ResultSrc=01 and RegWrite=1; 5 cycles.
  - STR (Funct[0]=0): MemWrite=1 in MEMWR only; 4 cycles.
- Conditional branch:
  - SUBS with ALUFlags=0100 and FlagW=11 sets Z=1.
  - Then BEQ (Op=10, Cond=0000): PCWrite=1 in BRANCH.
  - Repeat with BNE (Cond=0001): PCWrite=0 in BRANCH, but PCWrite=1 in FETCH.
- Failed condition:
  - ADDSNE with Z=1: RegWrite=0 in ALUWB; flags unchanged despite FlagW=11.
- PC as destination:
  - MOV with Rd=15 and Cond=AL: PCWrite=1 and RegWrite=1 in ALUWB.
- Reset mid-instruction:
  - Assert reset in MEMWR: MemWrite=0 that cycle.
  - Next state FETCH, NZCV=0000.
- Unsupported opcode:
  - Op=11: DECODE->FETCH with no RegWrite or MemWrite.
